// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle RISC-V load/store unit between the EX stage and a
//                variable-latency req/gnt/rvalid data bus. Checks funct3
//                legality and alignment, drives byte-lane enables and shifted
//                store data, and returns sign/zero-extended load data. Access
//                faults and bus timeouts raise a sticky halt cleared only by
//                reset.
//  Ports       : clk, rst (async, active-low)
//                req_*  : EX-stage request (valid/ready handshake)
//                rsp_*  : WB-stage response (valid/ready handshake)
//                mem_*  : data bus (req/gnt, rvalid, byte enables)
//                halt, fault_cause : sticky fault status
//                        (01 illegal funct3, 10 misaligned, 11 timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_store,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                halt,
   output logic [1:0]          fault_cause
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ      = 3'd1,
      S_WAIT_RSP = 3'd2,
      S_RESP     = 3'd3,
      S_FAULT    = 3'd4
   } state_t;

   state_t              state_q,  state_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic [BE_W-1:0]     be_q,     be_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic                we_q,     we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [OFF_W-1:0]    off_q,    off_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic [1:0]          cause_q,  cause_d;
   logic [TW-1:0]       timer_q,  timer_d;

   logic                legal;
   logic                misalign;
   logic [BE_W-1:0]     be_base;
   logic [OFF_W-1:0]    req_off;
   logic [DATA_W-1:0]   lane_data;
   logic [DATA_W-1:0]   load_ext;
   logic                timeout_hit;

   assign req_off = req_addr[OFF_W-1:0];

   // Decode of the incoming request: legality, alignment and base lane mask.
   always_comb begin
      legal    = 1'b0;
      misalign = 1'b0;
      be_base  = '0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b011:                 legal = (DATA_W == 64);
         3'b100, 3'b101:         legal = !req_store;
         3'b110:                 legal = !req_store && (DATA_W == 64);
         default:                legal = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b00: begin misalign = 1'b0;            be_base = BE_W'(8'h01); end
         2'b01: begin misalign = req_addr[0];     be_base = BE_W'(8'h03); end
         2'b10: begin misalign = |req_addr[1:0];  be_base = BE_W'(8'h0F); end
         default: begin misalign = |req_addr[2:0]; be_base = BE_W'(8'hFF); end
      endcase
   end

   // Load data: move the addressed lanes down to bit 0, then extend.
   always_comb begin
      lane_data = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_ext = DATA_W'($signed(lane_data[7:0]));
         3'b001:  load_ext = DATA_W'($signed(lane_data[15:0]));
         3'b010:  load_ext = DATA_W'($signed(lane_data[31:0]));
         3'b100:  load_ext = DATA_W'(lane_data[7:0]);
         3'b101:  load_ext = DATA_W'(lane_data[15:0]);
         3'b110:  load_ext = DATA_W'(lane_data[31:0]);
         default: load_ext = lane_data;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      rdata_d  = rdata_q;
      cause_d  = cause_q;
      timer_d  = timer_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               // Illegal funct3 takes priority over misalignment.
               if (!legal) begin
                  cause_d = CAUSE_ILLEGAL;
                  state_d = S_FAULT;
               end else if (misalign) begin
                  cause_d = CAUSE_MISALIGN;
                  state_d = S_FAULT;
               end else begin
                  addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  be_d     = be_base << req_off;
                  wdata_d  = req_wdata << {req_off, 3'b000};
                  we_d     = req_store;
                  funct3_d = req_funct3;
                  off_d    = req_off;
                  timer_d  = '0;
                  state_d  = S_REQ;
               end
            end
         end
         S_REQ: begin
            timer_d = timer_q + TW'(1);
            // A grant is not a completion, so the timeout still wins here.
            if (timeout_hit) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_FAULT;
            end else if (mem_gnt) begin
               state_d = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            timer_d = timer_q + TW'(1);
            if (mem_rvalid) begin
               rdata_d = we_q ? '0 : load_ext;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_FAULT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         off_q    <= '0;
         rdata_q  <= '0;
         cause_q  <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         rdata_q  <= rdata_d;
         cause_q  <= cause_d;
         timer_q  <= timer_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_rdata   = rdata_q;
   assign mem_req     = (state_q == S_REQ);
   assign mem_addr    = addr_q;
   assign mem_we      = we_q;
   assign mem_be      = be_q;
   assign mem_wdata   = wdata_q;
   assign halt        = (state_q == S_FAULT);
   assign fault_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed testbench for load_store_unit. A 32-bit instance
//                (TIMEOUT=8) and a 64-bit instance (TIMEOUT=64) share all
//                inputs; a selector picks which instance's outputs are checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_store, rsp_ready, mem_gnt, mem_rvalid;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, mem_rdata;

   logic        a_req_ready, a_rsp_valid, a_mem_req, a_mem_we, a_halt;
   logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic [1:0]  a_cause;
   logic        b_req_ready, b_rsp_valid, b_mem_req, b_mem_we, b_halt;
   logic [63:0] b_rsp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_be;
   logic [1:0]  b_cause;

   logic        sel;
   logic        o_req_ready, o_rsp_valid, o_mem_req, o_mem_we, o_halt;
   logic [63:0] o_rsp_rdata, o_mem_wdata;
   logic [31:0] o_mem_addr;
   logic [7:0]  o_mem_be;
   logic [1:0]  o_cause;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u32 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(a_req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
      .mem_req(a_mem_req), .mem_gnt(mem_gnt), .mem_addr(a_mem_addr),
      .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
      .halt(a_halt), .fault_cause(a_cause)
   );

   load_store_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(64)) u64 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(b_req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
      .mem_req(b_mem_req), .mem_gnt(mem_gnt), .mem_addr(b_mem_addr),
      .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .halt(b_halt), .fault_cause(b_cause)
   );

   always_comb begin
      o_req_ready = sel ? b_req_ready : a_req_ready;
      o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
      o_rsp_rdata = sel ? b_rsp_rdata : {32'h0, a_rsp_rdata};
      o_mem_req   = sel ? b_mem_req   : a_mem_req;
      o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
      o_mem_we    = sel ? b_mem_we    : a_mem_we;
      o_mem_be    = sel ? b_mem_be    : {4'h0, a_mem_be};
      o_mem_wdata = sel ? b_mem_wdata : {32'h0, a_mem_wdata};
      o_halt      = sel ? b_halt      : a_halt;
      o_cause     = sel ? b_cause     : a_cause;
   end

   typedef struct {
      logic        sel64;
      logic        store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [1:0]  cause;     // 0 = access expected to complete
      logic [31:0] e_addr;
      logic [7:0]  e_be;
      logic [63:0] e_wdata;
      logic [63:0] e_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      cycle();
      cycle();
      chk("rst_req_ready", {63'h0, o_req_ready}, 64'h1);
      chk("rst_halt",      {63'h0, o_halt},      64'h0);
      chk("rst_mem_req",   {63'h0, o_mem_req},   64'h0);
      chk("rst_rsp_valid", {63'h0, o_rsp_valid}, 64'h0);
      chk("rst_cause",     {62'h0, o_cause},     64'h0);
      rst = 1'b1;
      cycle();
   endtask

   task automatic check_bus(input vec_t v);
      chk("mem_req",   {63'h0, o_mem_req}, 64'h1);
      chk("mem_addr",  {32'h0, o_mem_addr}, {32'h0, v.e_addr});
      chk("mem_be",    {56'h0, o_mem_be},   {56'h0, v.e_be});
      chk("mem_we",    {63'h0, o_mem_we},   {63'h0, v.store});
      chk("mem_wdata", o_mem_wdata,         v.e_wdata);
   endtask

   // Accept one access, then play the bus with the given delays.
   task automatic run_access(input vec_t v, input int gnt_dly, input int rdy_dly);
      sel        = v.sel64;
      req_store  = v.store;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      chk("req_ready_idle", {63'h0, o_req_ready}, 64'h1);
      req_valid  = 1'b1;
      cycle();
      req_valid  = 1'b0;
      if (v.cause != 2'b00) begin
         chk("fault_halt",  {63'h0, o_halt},      64'h1);
         chk("fault_cause", {62'h0, o_cause},     {62'h0, v.cause});
         chk("fault_ready", {63'h0, o_req_ready}, 64'h0);
         for (int i = 0; i < 3; i++) begin
            chk("fault_no_req", {63'h0, o_mem_req}, 64'h0);
            cycle();
         end
         chk("fault_sticky", {63'h0, o_halt}, 64'h1);
         return;
      end
      for (int i = 0; i < gnt_dly; i++) begin
         check_bus(v);
         cycle();
      end
      check_bus(v);
      mem_gnt = 1'b1;
      cycle();
      mem_gnt = 1'b0;
      chk("req_dropped",   {63'h0, o_mem_req},   64'h0);
      chk("no_early_rsp",  {63'h0, o_rsp_valid}, 64'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
      for (int i = 0; i <= rdy_dly; i++) begin
         chk("rsp_valid", {63'h0, o_rsp_valid}, 64'h1);
         chk("rsp_rdata", o_rsp_rdata, v.e_rdata);
         if (i == rdy_dly) rsp_ready = 1'b1;
         cycle();
      end
      rsp_ready = 1'b0;
      chk("single_rsp",   {63'h0, o_rsp_valid}, 64'h0);
      chk("back_to_idle", {63'h0, o_req_ready}, 64'h1);
   endtask

   vec_t vt[21];
   vec_t v;

   initial begin
      rst = 1'b1;
      sel = 1'b0;
      idle_inputs();
      //          sel st  f3      addr          wdata                  rdata                  cause e_addr        e_be   e_wdata                e_rdata
      vt[0]  = '{1'b0,1'b0,3'b000,32'h0000_0103,64'h0,                 64'h80FF_0000,         2'd0,32'h0000_0100,8'h08,64'h0,                 64'hFFFF_FF80};
      vt[1]  = '{1'b0,1'b1,3'b001,32'h0000_0202,64'h0000_BEEF,         64'h1234_5678,         2'd0,32'h0000_0200,8'h0C,64'hBEEF_0000,         64'h0};
      vt[2]  = '{1'b0,1'b0,3'b100,32'h0000_0101,64'h0,                 64'h0000_A500,         2'd0,32'h0000_0100,8'h02,64'h0,                 64'h0000_00A5};
      vt[3]  = '{1'b0,1'b0,3'b001,32'h0000_0106,64'h0,                 64'h8001_0000,         2'd0,32'h0000_0104,8'h0C,64'h0,                 64'hFFFF_8001};
      vt[4]  = '{1'b0,1'b0,3'b101,32'h0000_0106,64'h0,                 64'h8001_0000,         2'd0,32'h0000_0104,8'h0C,64'h0,                 64'h0000_8001};
      vt[5]  = '{1'b0,1'b0,3'b010,32'h0000_0108,64'h0,                 64'hDEAD_BEEF,         2'd0,32'h0000_0108,8'h0F,64'h0,                 64'hDEAD_BEEF};
      vt[6]  = '{1'b0,1'b1,3'b000,32'h0000_0301,64'h1234_56AB,         64'h0,                 2'd0,32'h0000_0300,8'h02,64'h3456_AB00,         64'h0};
      vt[7]  = '{1'b0,1'b1,3'b010,32'h0000_0304,64'hCAFE_F00D,         64'h0,                 2'd0,32'h0000_0304,8'h0F,64'hCAFE_F00D,         64'h0};
      vt[8]  = '{1'b0,1'b0,3'b010,32'h0000_0102,64'h0,                 64'h0,                 2'd2,32'h0,8'h0,64'h0,64'h0};
      vt[9]  = '{1'b0,1'b0,3'b011,32'h0000_0008,64'h0,                 64'h0,                 2'd1,32'h0,8'h0,64'h0,64'h0};
      vt[10] = '{1'b0,1'b0,3'b011,32'h0000_0003,64'h0,                 64'h0,                 2'd1,32'h0,8'h0,64'h0,64'h0};
      vt[11] = '{1'b0,1'b1,3'b100,32'h0000_0000,64'h0,                 64'h0,                 2'd1,32'h0,8'h0,64'h0,64'h0};
      vt[12] = '{1'b0,1'b1,3'b001,32'h0000_0201,64'h0,                 64'h0,                 2'd2,32'h0,8'h0,64'h0,64'h0};
      vt[13] = '{1'b1,1'b0,3'b011,32'h0000_0008,64'h0,                 64'hFFFF_FFFF_0000_0001,2'd0,32'h0000_0008,8'hFF,64'h0,                64'hFFFF_FFFF_0000_0001};
      vt[14] = '{1'b1,1'b0,3'b010,32'h0000_0014,64'h0,                 64'h8000_0000_0000_0000,2'd0,32'h0000_0010,8'hF0,64'h0,                64'hFFFF_FFFF_8000_0000};
      vt[15] = '{1'b1,1'b0,3'b110,32'h0000_0014,64'h0,                 64'h8000_0000_0000_0000,2'd0,32'h0000_0010,8'hF0,64'h0,                64'h0000_0000_8000_0000};
      vt[16] = '{1'b1,1'b1,3'b011,32'h0000_0020,64'h0123_4567_89AB_CDEF,64'h0,                2'd0,32'h0000_0020,8'hFF,64'h0123_4567_89AB_CDEF,64'h0};
      vt[17] = '{1'b1,1'b1,3'b000,32'h0000_0027,64'h0000_0000_0000_00EE,64'h0,                2'd0,32'h0000_0020,8'h80,64'hEE00_0000_0000_0000,64'h0};
      vt[18] = '{1'b1,1'b0,3'b011,32'h0000_0004,64'h0,                 64'h0,                 2'd2,32'h0,8'h0,64'h0,64'h0};
      vt[19] = '{1'b1,1'b1,3'b111,32'h0000_0000,64'h0,                 64'h0,                 2'd1,32'h0,8'h0,64'h0,64'h0};
      vt[20] = '{1'b1,1'b0,3'b000,32'h0000_0009,64'h0,                 64'h0000_0000_0000_7F00,2'd0,32'h0000_0008,8'h02,64'h0,                64'h0000_0000_0000_007F};

      for (int k = 0; k < 21; k++) begin
         sel = vt[k].sel64;
         do_reset();
         run_access(vt[k], 0, 0);
      end

      // Misaligned word faults, then reset clears the sticky halt.
      sel = 1'b0;
      do_reset();
      run_access(vt[8], 0, 0);
      rst = 1'b0;
      #1;
      chk("rst_clears_halt",  {63'h0, o_halt},      64'h0);
      chk("rst_ready_again",  {63'h0, o_req_ready}, 64'h1);
      cycle();
      rst = 1'b1;
      cycle();

      // Grant withheld 5 cycles, response consumer stalls 3 cycles.
      do_reset();
      v = '{1'b0,1'b0,3'b010,32'h0000_0040,64'h0,64'h1357_9BDF,2'd0,32'h0000_0040,8'h0F,64'h0,64'h1357_9BDF};
      run_access(v, 5, 3);

      // No grant: timeout after 8 cycles in REQ (TIMEOUT=8).
      do_reset();
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0080;
      req_valid  = 1'b1;
      cycle();
      req_valid  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("to_req_held", {63'h0, o_mem_req}, 64'h1);
         cycle();
      end
      chk("to_req_drop", {63'h0, o_mem_req}, 64'h0);
      chk("to_halt",     {63'h0, o_halt},    64'h1);
      chk("to_cause",    {62'h0, o_cause},   64'h3);
      mem_gnt = 1'b1;
      cycle();
      mem_gnt = 1'b0;
      chk("to_gnt_ignored", {63'h0, o_mem_req}, 64'h0);

      // Reset asserted while waiting for rvalid; late rvalid must be ignored.
      do_reset();
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0044;
      req_valid  = 1'b1;
      cycle();
      req_valid  = 1'b0;
      mem_gnt    = 1'b1;
      cycle();
      mem_gnt    = 1'b0;
      rst        = 1'b0;
      #1;
      chk("mid_rst_addr",  {32'h0, o_mem_addr},  64'h0);
      chk("mid_rst_be",    {56'h0, o_mem_be},    64'h0);
      chk("mid_rst_ready", {63'h0, o_req_ready}, 64'h1);
      cycle();
      rst        = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hFFFF_FFFF;
      cycle();
      mem_rvalid = 1'b0;
      chk("late_rvalid_rsp",   {63'h0, o_rsp_valid}, 64'h0);
      chk("late_rvalid_ready", {63'h0, o_req_ready}, 64'h1);
      chk("late_rvalid_rdata", o_rsp_rdata,          64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
